ekf_stage_sched: RTL and testbench

Stage scheduler that sits in front of the RSA and sequences the EKF-SLAM stages. It accepts odometry and landmark-observation requests from the host, orders them so that predict runs before correction, and issues one-hot stage requests to the RSA over the `stage_val`/`stage_rdy` handshake. It waits for stage completion with a watchdog, owns the authoritative `landmark_num` count, and drives the `l_k` index into the RSA.

---
 rtl/ekf_pkg.sv | 25 ++
 rtl/ekf_stage_watchdog.sv | 29 ++
 rtl/ekf_stage_sched.sv | 192 +++++++++++++++++++
 tb/tb_ekf_stage_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ekf_pkg.sv
// Shared encodings for the EKF-SLAM stage scheduler: one-hot stage codes,
// scheduler FSM states and error codes reported to the host.
package ekf_pkg;

  // One-hot stage codes as seen by the RSA; IDLE means no stage in flight.
  localparam logic [2:0] IDLE      = 3'b000;
  localparam logic [2:0] STAGE_PRD = 3'b001;
  localparam logic [2:0] STAGE_NEW = 3'b010;
  localparam logic [2:0] STAGE_UPD = 3'b100;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Error codes carried on err_code.
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_ID  = 2'd1;
  localparam logic [1:0] ERR_FULL    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/ekf_stage_watchdog.sv
// Watchdog counter for a stage in flight. Cleared while no stage is running,
// counts while enabled and saturates at WD_MAX, where expired is asserted.
module ekf_stage_watchdog
  import ekf_pkg::*;
#(
  parameter int               WD_DW  = 16,
  parameter logic [WD_DW-1:0] WD_MAX = '1
) (
  input  logic clk,
  input  logic sys_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [WD_DW-1:0] r_cnt;

  // Count enabled cycles, holding at WD_MAX until cleared.
  always_ff @(posedge clk) begin
    if (sys_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != WD_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == WD_MAX);

endmodule

// File: rtl/ekf_stage_sched.sv
// EKF-SLAM stage scheduler: buffers one predict and one observation request,
// issues predict ahead of correction as one-hot stage requests to the RSA,
// guards each running stage with a watchdog and owns the landmark count.
module ekf_stage_sched
  import ekf_pkg::*;
#(
  parameter int               ROW_LEN = 10,
  parameter int               MAX_LM  = 512,
  parameter int               WD_DW   = 16,
  parameter logic [WD_DW-1:0] WD_MAX  = 16'hFFFF
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               odo_val,
  output logic               odo_rdy,
  input  logic               obs_val,
  input  logic               obs_new,
  input  logic [ROW_LEN-1:0] obs_id,
  output logic               obs_rdy,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  input  logic               stage_done,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic [ROW_LEN-1:0] l_k,
  output logic               busy,
  output logic [2:0]         cur_stage,
  output logic               err_pulse,
  output logic [1:0]         err_code
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_stage;
  logic [2:0]         w_stage_nxt;
  logic [ROW_LEN-1:0] r_lk;
  logic [ROW_LEN-1:0] w_lk_nxt;
  logic               r_pred_pend;
  logic               r_obs_pend;
  logic               r_obs_new;
  logic [ROW_LEN-1:0] r_obs_id;
  logic [ROW_LEN-1:0] r_lm;
  logic               r_err_pulse;
  logic [1:0]         r_err_code;
  logic               w_err;
  logic [1:0]         w_err_code;
  logic               w_clr_pred;
  logic               w_clr_obs;
  logic               w_inc_lm;
  logic               w_hs;
  logic               w_lm_full;
  logic               w_wd_en;
  logic               w_expired;

  assign w_hs      = (r_state == ST_REQ) && ((r_stage & stage_rdy) != 3'b000);
  assign w_lm_full = (r_lm == ROW_LEN'(MAX_LM));
  // The handshake edge already counts, so a stage gets exactly WD_MAX RUN cycles.
  assign w_wd_en   = (r_state == ST_RUN) || w_hs;

  ekf_stage_watchdog #(
    .WD_DW  (WD_DW),
    .WD_MAX (WD_MAX)
  ) u_wd (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .i_clr     (~w_wd_en),
    .i_en      (w_wd_en),
    .o_expired (w_expired)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: stage selection, validation, handshake, completion, timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_lk_nxt    = r_lk;
    w_err       = 1'b0;
    w_err_code  = r_err_code;
    w_clr_pred  = 1'b0;
    w_clr_obs   = 1'b0;
    w_inc_lm    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pred_pend) begin
          w_state_nxt = ST_REQ;
          w_stage_nxt = STAGE_PRD;
          w_lk_nxt    = '0;
        end else if (r_obs_pend) begin
          if (!r_obs_new && (r_obs_id >= r_lm)) begin
            w_err      = 1'b1;
            w_err_code = ERR_BAD_ID;
            w_clr_obs  = 1'b1;
          end else if (r_obs_new && w_lm_full) begin
            w_err      = 1'b1;
            w_err_code = ERR_FULL;
            w_clr_obs  = 1'b1;
          end else begin
            w_state_nxt = ST_REQ;
            w_stage_nxt = r_obs_new ? STAGE_NEW : STAGE_UPD;
            w_lk_nxt    = r_obs_new ? r_lm : r_obs_id;
          end
        end
      end
      ST_REQ: begin
        if (w_hs) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stage_done) begin
          w_state_nxt = ST_DONE;
        end else if (w_expired) begin
          w_state_nxt = ST_IDLE;
          w_err       = 1'b1;
          w_err_code  = ERR_TIMEOUT;
          w_clr_pred  = (r_stage == STAGE_PRD);
          w_clr_obs   = (r_stage != STAGE_PRD);
          w_stage_nxt = IDLE;
          w_lk_nxt    = '0;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_inc_lm    = (r_stage == STAGE_NEW);
        w_clr_pred  = (r_stage == STAGE_PRD);
        w_clr_obs   = (r_stage != STAGE_PRD);
        w_stage_nxt = IDLE;
        w_lk_nxt    = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control registers: pending flags, active stage, landmark count, error report.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_stage     <= IDLE;
      r_lk        <= '0;
      r_pred_pend <= 1'b0;
      r_obs_pend  <= 1'b0;
      r_lm        <= '0;
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_stage     <= w_stage_nxt;
      r_lk        <= w_lk_nxt;
      r_err_pulse <= w_err;
      r_err_code  <= w_err_code;
      if (w_inc_lm) begin
        r_lm <= r_lm + 1'b1;
      end
      if (w_clr_pred) begin
        r_pred_pend <= 1'b0;
      end else if (odo_val && !r_pred_pend) begin
        r_pred_pend <= 1'b1;
      end
      if (w_clr_obs) begin
        r_obs_pend <= 1'b0;
      end else if (obs_val && !r_obs_pend) begin
        r_obs_pend <= 1'b1;
      end
    end
  end

  // Observation payload, only meaningful while r_obs_pend is set.
  always_ff @(posedge clk) begin
    if (obs_val && !r_obs_pend) begin
      r_obs_new <= obs_new;
      r_obs_id  <= obs_id;
    end
  end

  assign odo_rdy      = ~r_pred_pend;
  assign obs_rdy      = ~r_obs_pend;
  assign stage_val    = (r_state == ST_REQ) ? r_stage : IDLE;
  assign busy         = (r_state != ST_IDLE);
  assign cur_stage    = r_stage;
  assign l_k          = r_lk;
  assign landmark_num = r_lm;
  assign err_pulse    = r_err_pulse;
  assign err_code     = r_err_code;

endmodule

// File: tb/tb_ekf_stage_sched.sv
// Bench for ekf_stage_sched: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a transaction-level model.
module tb_ekf_stage_sched;

  localparam int ROW_LEN = 10;
  localparam int MAXLM   = 4;
  localparam int WDMAX   = 8;

  logic               clk = 1'b0;
  logic               sys_rst;
  logic               odo_val;
  logic               odo_rdy;
  logic               obs_val;
  logic               obs_new;
  logic [ROW_LEN-1:0] obs_id;
  logic               obs_rdy;
  logic [2:0]         stage_val;
  logic [2:0]         stage_rdy;
  logic               stage_done;
  logic [ROW_LEN-1:0] landmark_num;
  logic [ROW_LEN-1:0] l_k;
  logic               busy;
  logic [2:0]         cur_stage;
  logic               err_pulse;
  logic [1:0]         err_code;

  int checks = 0;
  int errors = 0;

  ekf_stage_sched #(
    .ROW_LEN (ROW_LEN),
    .MAX_LM  (MAXLM),
    .WD_DW   (16),
    .WD_MAX  (16'(WDMAX))
  ) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .odo_val      (odo_val),
    .odo_rdy      (odo_rdy),
    .obs_val      (obs_val),
    .obs_new      (obs_new),
    .obs_id       (obs_id),
    .obs_rdy      (obs_rdy),
    .stage_val    (stage_val),
    .stage_rdy    (stage_rdy),
    .stage_done   (stage_done),
    .landmark_num (landmark_num),
    .l_k          (l_k),
    .busy         (busy),
    .cur_stage    (cur_stage),
    .err_pulse    (err_pulse),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // phase: 0 nothing in flight, 1 offering stage, 2 stage executing, 3 completing
  int         m_phase = 0;
  logic [2:0] m_stage = 3'b000;
  int         m_lk = 0, m_lm = 0, m_wd = 0, m_oid = 0, m_errc = 0;
  bit         m_pred = 0, m_obs = 0, m_onew = 0, m_errp = 0;

  task automatic retire_stage();
    if (m_stage == 3'b001) m_pred = 0;
    else m_obs = 0;
    m_stage = 3'b000;
    m_lk    = 0;
    m_phase = 0;
  endtask

  task automatic model_step();
    bit cap_o, cap_b;
    if (sys_rst) begin
      m_phase = 0; m_stage = 3'b000; m_lk = 0; m_lm = 0; m_wd = 0;
      m_pred = 0; m_obs = 0; m_errp = 0; m_errc = 0;
      return;
    end
    cap_o  = odo_val && !m_pred;
    cap_b  = obs_val && !m_obs;
    m_errp = 0;
    case (m_phase)
      0: begin
        if (m_pred) begin
          m_phase = 1; m_stage = 3'b001; m_lk = 0;
        end else if (m_obs) begin
          if (!m_onew && m_oid >= m_lm) begin
            m_errp = 1; m_errc = 1; m_obs = 0;
          end else if (m_onew && m_lm == MAXLM) begin
            m_errp = 1; m_errc = 2; m_obs = 0;
          end else begin
            m_phase = 1;
            m_stage = m_onew ? 3'b010 : 3'b100;
            m_lk    = m_onew ? m_lm : m_oid;
          end
        end
      end
      1: if ((m_stage & stage_rdy) != 3'b000) begin m_phase = 2; m_wd = 0; end
      2: begin
        m_wd++;
        if (stage_done) m_phase = 3;
        else if (m_wd == WDMAX) begin m_errp = 1; m_errc = 3; retire_stage(); end
      end
      default: begin
        if (m_stage == 3'b010) m_lm++;
        retire_stage();
      end
    endcase
    if (cap_o) m_pred = 1;
    if (cap_b) begin m_obs = 1; m_onew = obs_new; m_oid = int'(obs_id); end
  endtask

  // Advance the model on every edge and compare all outputs shortly after it.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      chk("odo_rdy",   32'(odo_rdy),      32'(!m_pred));
      chk("obs_rdy",   32'(obs_rdy),      32'(!m_obs));
      chk("stage_val", 32'(stage_val),    32'((m_phase == 1) ? m_stage : 3'b000));
      chk("busy",      32'(busy),         32'(m_phase != 0));
      chk("cur_stage", 32'(cur_stage),    32'(m_stage));
      chk("l_k",       32'(l_k),          32'(m_lk));
      chk("lm_num",    32'(landmark_num), 32'(m_lm));
      chk("err_pulse", 32'(err_pulse),    32'(m_errp));
      chk("err_code",  32'(err_code),     32'(m_errc));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic pulse_odo();
    odo_val = 1'b1;
    @(negedge clk);
    odo_val = 1'b0;
  endtask

  task automatic pulse_obs(input logic nw, input int id);
    obs_val = 1'b1; obs_new = nw; obs_id = ROW_LEN'(id);
    @(negedge clk);
    obs_val = 1'b0;
  endtask

  // Wait (bounded) for an issued stage, grant it, then complete it.
  task automatic serve(input logic [2:0] exp_stage, input int exp_lk);
    int n = 0;
    while (stage_val == 3'b000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("serve_stage", 32'(stage_val), 32'(exp_stage));
    chk("serve_lk",    32'(l_k),       32'(exp_lk));
    @(negedge clk);
    @(negedge clk);
    stage_done = 1'b1;
    @(negedge clk);
    stage_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    sys_rst = 1'b1; odo_val = 1'b0; obs_val = 1'b0; obs_new = 1'b0;
    obs_id = '0; stage_rdy = 3'b111; stage_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_odo_rdy", 32'(odo_rdy), 32'd1);
    chk("rst_obs_rdy", 32'(obs_rdy), 32'd1);
    chk("rst_busy",    32'(busy),    32'd0);
    sys_rst = 1'b0;
    @(negedge clk);

    // Basic predict with a done pulse a few cycles into RUN.
    pulse_odo();
    @(negedge clk);
    chk("prd_issue", 32'(stage_val), 32'b001);
    @(negedge clk);
    chk("prd_drop",  32'(stage_val), 32'b000);
    chk("prd_run",   32'(busy),      32'd1);
    repeat (4) @(negedge clk);
    stage_done = 1'b1;
    @(negedge clk);
    stage_done = 1'b0;
    @(negedge clk);
    chk("prd_busy_end", 32'(busy),    32'd0);
    chk("prd_rdy_end",  32'(odo_rdy), 32'd1);

    // Predict and new-landmark requested together: predict goes first.
    odo_val = 1'b1; obs_val = 1'b1; obs_new = 1'b1; obs_id = '0;
    @(negedge clk);
    odo_val = 1'b0; obs_val = 1'b0;
    serve(3'b001, 0);
    serve(3'b010, 0);
    chk("order_lm", 32'(landmark_num), 32'd1);

    // Grow to three landmarks, then exercise the update range check.
    pulse_obs(1'b1, 0); serve(3'b010, 1);
    pulse_obs(1'b1, 0); serve(3'b010, 2);
    chk("lm_three", 32'(landmark_num), 32'd3);
    pulse_obs(1'b0, 3);
    @(negedge clk);
    chk("badid_pulse", 32'(err_pulse), 32'd1);
    chk("badid_code",  32'(err_code),  32'd1);
    chk("badid_noval", 32'(stage_val), 32'd0);
    pulse_obs(1'b0, 2);
    serve(3'b100, 2);

    // Fill the table, then a further new landmark is refused.
    pulse_obs(1'b1, 0); serve(3'b010, 3);
    chk("lm_full", 32'(landmark_num), 32'd4);
    pulse_obs(1'b1, 0);
    @(negedge clk);
    chk("full_pulse", 32'(err_pulse),    32'd1);
    chk("full_code",  32'(err_code),     32'd2);
    chk("full_lm",    32'(landmark_num), 32'd4);

    // Stall in REQ, ignore non-matching ready bits, then time out in RUN.
    stage_rdy = 3'b000;
    pulse_obs(1'b0, 1);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk("stall_hold", 32'(stage_val), 32'b100);
      @(negedge clk);
    end
    stage_rdy = 3'b011;
    repeat (3) @(negedge clk);
    chk("stall_other", 32'(stage_val), 32'b100);
    stage_rdy = 3'b100;
    @(negedge clk);
    stage_rdy = 3'b111;
    repeat (7) @(negedge clk);
    chk("wd_not_yet", 32'(busy), 32'd1);
    @(negedge clk);
    chk("wd_pulse", 32'(err_pulse),    32'd1);
    chk("wd_code",  32'(err_code),     32'd3);
    chk("wd_lm",    32'(landmark_num), 32'd4);
    chk("wd_idle",  32'(busy),         32'd0);

    // Reset while a stage runs, then a spurious done while idle.
    pulse_odo();
    @(negedge clk);
    @(negedge clk);
    obs_val = 1'b1; obs_new = 1'b1;
    sys_rst = 1'b1;
    @(negedge clk);
    obs_val = 1'b0;
    chk("mid_rst_busy", 32'(busy),         32'd0);
    chk("mid_rst_lm",   32'(landmark_num), 32'd0);
    chk("mid_rst_odo",  32'(odo_rdy),      32'd1);
    chk("mid_rst_code", 32'(err_code),     32'd0);
    sys_rst = 1'b0;
    stage_done = 1'b1;
    @(negedge clk);
    stage_done = 1'b0;
    chk("spur_busy",  32'(busy),      32'd0);
    chk("spur_stage", 32'(cur_stage), 32'd0);
    @(negedge clk);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      sys_rst    = ($urandom_range(0, 299) == 0);
      odo_val    = ($urandom_range(0, 3) == 0);
      obs_val    = ($urandom_range(0, 2) == 0);
      obs_new    = $urandom_range(0, 1) == 1;
      obs_id     = ROW_LEN'($urandom_range(0, 5));
      stage_rdy  = 3'($urandom_range(0, 7));
      stage_done = ($urandom_range(0, 4) == 0);
      @(negedge clk);
    end
    sys_rst = 1'b0; odo_val = 1'b0; obs_val = 1'b0; stage_done = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
